// File: rtl/counter_driver.sv
// Turns inc/dec events into saturating 1..3 step commands; all outputs registered, req->command 2 edges min.
// Backpressure: a held command is frozen until cmd_ready; events accumulate in 0..7 pending counts and drop beyond.
module counter_driver (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] start_value,
    input  logic       inc_req,
    input  logic       dec_req,
    input  logic       cmd_ready,
    output logic       reinit,
    output logic [3:0] initial_value,
    output logic       incr_valid,
    output logic [1:0] incr,
    output logic       decr_valid,
    output logic [1:0] decr,
    output logic [3:0] shadow,
    output logic       inc_drop,
    output logic       dec_drop,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;

    state_t     state_q, state_d;
    logic [2:0] inc_pend_q, inc_pend_d;
    logic [2:0] dec_pend_q, dec_pend_d;
    logic       reinit_d, incr_valid_d, decr_valid_d, inc_drop_d, dec_drop_d, busy_d;
    logic [3:0] init_val_d, shadow_d;
    logic [1:0] incr_d, decr_d;

    logic [1:0] inc_cap, dec_cap, inc_amt, dec_amt, inc_iss, dec_iss;
    logic [4:0] inc_room;
    logic [3:0] inc_sum, dec_sum;
    logic       cmd_load;

    // Decrement first so the freed headroom can be spent by the increment in the same command.
    always_comb begin
        dec_cap  = (dec_pend_q > 3'd3) ? 2'd3 : dec_pend_q[1:0];
        dec_amt  = ({2'b00, dec_cap} > shadow) ? shadow[1:0] : dec_cap;
        inc_cap  = (inc_pend_q > 3'd3) ? 2'd3 : inc_pend_q[1:0];
        inc_room = 5'd15 - {1'b0, shadow} + {3'b000, dec_amt};
        inc_amt  = (inc_room < {3'b000, inc_cap}) ? inc_room[1:0] : inc_cap;
        cmd_load = !(incr_valid || decr_valid) || cmd_ready;
    end

    always_comb begin
        state_d      = state_q;
        inc_pend_d   = inc_pend_q;
        dec_pend_d   = dec_pend_q;
        reinit_d     = reinit;
        init_val_d   = initial_value;
        incr_valid_d = incr_valid;
        incr_d       = incr;
        decr_valid_d = decr_valid;
        decr_d       = decr;
        shadow_d     = shadow;
        inc_drop_d   = 1'b0;
        dec_drop_d   = 1'b0;
        inc_iss      = 2'd0;
        dec_iss      = 2'd0;
        inc_sum      = 4'd0;
        dec_sum      = 4'd0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = INIT;
                    reinit_d   = 1'b1;
                    init_val_d = start_value;
                end
            end
            INIT: begin
                // initial_value doubles as the latched load value
                if (cmd_ready) begin
                    state_d    = RUN;
                    shadow_d   = initial_value;
                    inc_pend_d = 3'd0;
                    dec_pend_d = 3'd0;
                    reinit_d   = 1'b0;
                    init_val_d = 4'd0;
                end
            end
            RUN: begin
                if (start) begin
                    state_d      = INIT;
                    reinit_d     = 1'b1;
                    init_val_d   = start_value;
                    incr_valid_d = 1'b0;
                    incr_d       = 2'd0;
                    decr_valid_d = 1'b0;
                    decr_d       = 2'd0;
                    inc_pend_d   = 3'd0;
                    dec_pend_d   = 3'd0;
                end else begin
                    if (cmd_load) begin
                        incr_valid_d = (inc_amt != 2'd0);
                        incr_d       = inc_amt;
                        decr_valid_d = (dec_amt != 2'd0);
                        decr_d       = dec_amt;
                        shadow_d     = shadow + {2'b00, inc_amt} - {2'b00, dec_amt};
                        inc_iss      = inc_amt;
                        dec_iss      = dec_amt;
                    end
                    inc_sum = {1'b0, inc_pend_q} - {2'b00, inc_iss} + {3'b000, inc_req};
                    dec_sum = {1'b0, dec_pend_q} - {2'b00, dec_iss} + {3'b000, dec_req};
                    inc_drop_d = inc_sum[3];
                    dec_drop_d = dec_sum[3];
                    inc_pend_d = inc_sum[3] ? 3'd7 : inc_sum[2:0];
                    dec_pend_d = dec_sum[3] ? 3'd7 : dec_sum[2:0];
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == INIT) ||
                 ((state_d == RUN) && (incr_valid_d || decr_valid_d ||
                                       (inc_pend_d != 3'd0) || (dec_pend_d != 3'd0)));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            inc_pend_q    <= 3'd0;
            dec_pend_q    <= 3'd0;
            reinit        <= 1'b0;
            initial_value <= 4'd0;
            incr_valid    <= 1'b0;
            incr          <= 2'd0;
            decr_valid    <= 1'b0;
            decr          <= 2'd0;
            shadow        <= 4'd0;
            inc_drop      <= 1'b0;
            dec_drop      <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            inc_pend_q    <= inc_pend_d;
            dec_pend_q    <= dec_pend_d;
            reinit        <= reinit_d;
            initial_value <= init_val_d;
            incr_valid    <= incr_valid_d;
            incr          <= incr_d;
            decr_valid    <= decr_valid_d;
            decr          <= decr_d;
            shadow        <= shadow_d;
            inc_drop      <= inc_drop_d;
            dec_drop      <= dec_drop_d;
            busy          <= busy_d;
        end
    end

endmodule

// File: doc/counter_driver.md
COUNTER_DRIVER -- requirements
Module: counter_driver

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: the block has one clock, and reset is synchronous and active-low (rst=0 sampled at a clk edge resets the block).
REQ-003 SHALL have port start, input, 1 bit: request to (re)initialise the downstream counter.
REQ-004 SHALL have port start_value, input, 4 bits: value to load on start, sampled in the cycle start=1.
REQ-005 SHALL have port inc_req, input, 1 bit: one increment event per cycle.
REQ-006 SHALL have port dec_req, input, 1 bit: one decrement event per cycle.
REQ-007 SHALL have port cmd_ready, input, 1 bit: downstream counter accepts the current command this cycle.
REQ-008 SHALL have port reinit, output, 1 bit: load command to the counter.
REQ-009 SHALL have port initial_value, output, 4 bits: load value, meaningful when reinit=1.
REQ-010 SHALL have ports incr_valid/incr, outputs, 1/2 bits: increment command and amount (1..3).
REQ-011 SHALL have ports decr_valid/decr, outputs, 1/2 bits: decrement command and amount (1..3).
REQ-012 SHALL have port shadow, output, 4 bits: counter value once all issued commands are accepted.
REQ-013 SHALL have ports inc_drop/dec_drop, outputs, 1 bit each: one-cycle pulse when an event is lost to saturation.
REQ-014 SHALL have port busy, output, 1 bit: high in INIT, or in RUN while a command is held or either pending count is nonzero.

Function
REQ-015 SHALL implement FSM states IDLE, INIT, RUN.
- IDLE: inc_req/dec_req ignored, with no drop pulses; start=1 -> INIT.
REQ-016 INIT:
- reinit=1 and initial_value=latched start_value; no incr/decr valid.
- Held until cmd_ready=1.
- In the accept cycle: shadow<=start_value, both pending counts<=0, next state RUN.
REQ-017 RUN, start=1 -> INIT next cycle.
- Pending counts cleared; any held command discarded.
- start has priority over all other RUN activity.
REQ-018 inc_pend and dec_pend SHALL each be a 3-bit count in the range 0..7.
- next = pend - issued + req.
- A result above 7 saturates at 7 and pulses the matching drop output in the same cycle.
REQ-019 Command register SHALL load when it is empty or cmd_ready=1, computing:
- dec_amt = min(dec_pend, 3, shadow)
- inc_amt = min(inc_pend, 3, 15 - shadow + dec_amt)
REQ-020 On that load:
- incr_valid=(inc_amt>0), incr=inc_amt, else incr=0; decr likewise.
- shadow <= shadow + inc_amt - dec_amt, with no wrap (always 0..15).
- A computed all-zero command leaves the register empty.
REQ-021 While a command is held and cmd_ready=0:
- reinit, initial_value, incr_valid, incr, decr_valid, decr SHALL remain stable.
- The register SHALL NOT reload.
REQ-022 Latency: a req sampled at edge N SHALL be issuable in the command output after edge N+1 at the earliest; same-cycle bypass from req to output is prohibited.
REQ-023 All outputs SHALL be registered.
REQ-024 Simultaneous inc_req and dec_req SHALL both be counted; no netting occurs in the pending counts.

Reset
REQ-025 On rst=0 at an edge:
- State=IDLE, pending counts=0, command register empty, shadow=0.
- All outputs 0.
REQ-026 Reset SHALL override start, cmd_ready and reqs in that cycle, including mid-INIT and mid-RUN with a held command.

Verification
REQ-027 Reset, start=1 with start_value=5, cmd_ready=1 -> reinit=1 and initial_value=5 for one cycle; then shadow=5, state RUN, busy=0.
REQ-028 RUN with shadow=5, inc_req=1 for 4 cycles, cmd_ready=1 -> incr commands totalling 4, each amount 1..3; final shadow=9.
REQ-029 shadow=14, inc_pend=3, dec_pend=0 -> incr=1 issued; shadow=15; inc_pend=2 remains; busy=1.
REQ-030 cmd_ready=0 for 10 cycles with inc_req=1 -> held command outputs stable; inc_pend saturates at 7; inc_drop pulses on each later event.
REQ-031 shadow=1, dec_pend=3, inc_pend=2 -> dec_amt=1, inc_amt=2; decr=1 and incr=2 in one command; shadow=2.
REQ-032 rst=0 asserted while a command is held in RUN -> next cycle all outputs 0, state IDLE; an inc_req in IDLE gives no drop and no command.
